oi_wr_arbiter: RTL

Two-port write arbiter for the output-image (OI) frame-buffer write master. It shares one Avalon-MM-style write port, with address/data/wrreq/waitrequest, between the frame-copy pixel writer (port 0) and the face-box drawer (port 1). Arbitration is round-robin with a bounded grant hold, so a long rectangle draw cannot starve the pixel stream. It sits between both writers and the SDRAM/SRAM controller write interface.

---
 rtl/oi_pkg.sv | 27 ++
 rtl/oi_wr_arbiter_if.sv | 33 +++
 rtl/oi_sat_counter.sv | 25 ++
 rtl/oi_wr_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/oi_pkg.sv
// Shared constants and types for the output-image frame-buffer write path.
package oi_pkg;

  localparam int unsigned OI_ADDR_W = 32;
  localparam int unsigned OI_DATA_W = 32;
  localparam int unsigned HOLD_W    = 8;

  localparam logic [OI_DATA_W-1:0] OI_BOX_COLOUR = 32'hF800F800;

  // Grant encoding doubles as the one-hot oGrant value.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_P0   = 2'b01,
    GNT_P1   = 2'b10
  } grant_e;

  typedef struct packed {
    logic [OI_ADDR_W-1:0] addr;
    logic [OI_DATA_W-1:0] data;
    logic                 wrreq;
  } wr_req_t;

  function automatic grant_e port_grant(input logic port);
    return port ? GNT_P1 : GNT_P0;
  endfunction

endpackage

// File: rtl/oi_wr_arbiter_if.sv
// Bundle of the two writer ports, the shared master port and arbiter status.
interface oi_wr_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  import oi_pkg::*;

  logic [OI_ADDR_W-1:0] iAddr_0;
  logic [OI_DATA_W-1:0] iData_0;
  logic                 iWrreq_0;
  logic                 oWait_0;
  logic [OI_ADDR_W-1:0] iAddr_1;
  logic [OI_DATA_W-1:0] iData_1;
  logic                 iWrreq_1;
  logic                 oWait_1;
  logic [OI_ADDR_W-1:0] oAddr_OI;
  logic [OI_DATA_W-1:0] oData_to_OI;
  logic                 oWrreq_OI;
  logic                 iWrite_wait_request;
  logic [1:0]           oGrant;
  logic [CNT_W-1:0]     oBeats_0;
  logic [CNT_W-1:0]     oBeats_1;

  modport slave (
    input  iAddr_0, iData_0, iWrreq_0, iAddr_1, iData_1, iWrreq_1, iWrite_wait_request,
    output oWait_0, oWait_1, oAddr_OI, oData_to_OI, oWrreq_OI, oGrant, oBeats_0, oBeats_1
  );

  modport master (
    output iAddr_0, iData_0, iWrreq_0, iAddr_1, iData_1, iWrreq_1, iWrite_wait_request,
    input  oWait_0, oWait_1, oAddr_OI, oData_to_OI, oWrreq_OI, oGrant, oBeats_0, oBeats_1
  );

endinterface

// File: rtl/oi_sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones.
module oi_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/oi_wr_arbiter.sv
// Round-robin two-port write arbiter with bounded grant hold, sharing one
// Avalon-style write master between the pixel writer (0) and box drawer (1).
module oi_wr_arbiter
  import oi_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           iClk,
  input  logic           iReset_n,
  oi_wr_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  grant_e            grant_q, grant_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  wr_req_t req0, req1, sel;
  logic    accept, stall;
  logic    cur_p1, own_req, other_req, expire;

  assign req0 = '{addr: bus.iAddr_0, data: bus.iData_0, wrreq: bus.iWrreq_0};
  assign req1 = '{addr: bus.iAddr_1, data: bus.iData_1, wrreq: bus.iWrreq_1};

  // State register: grant, most recently granted port, beats in this grant.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      grant_q <= GNT_IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state: the grant is frozen whenever a beat is stalled.
  always_comb begin
    grant_d   = grant_q;
    last_d    = last_q;
    hold_d    = hold_q;
    cur_p1    = (grant_q == GNT_P1);
    own_req   = cur_p1 ? bus.iWrreq_1 : bus.iWrreq_0;
    other_req = cur_p1 ? bus.iWrreq_0 : bus.iWrreq_1;
    expire    = 1'b0;
    case (grant_q)
      GNT_IDLE: begin
        hold_d = '0;
        if (bus.iWrreq_0 && (!bus.iWrreq_1 || last_q)) begin
          grant_d = GNT_P0;
          last_d  = 1'b0;
        end else if (bus.iWrreq_1) begin
          grant_d = GNT_P1;
          last_d  = 1'b1;
        end
      end
      GNT_P0, GNT_P1: begin
        if (!stall) begin
          expire = !own_req || (accept && ((hold_q + HOLD_W'(1)) == HOLD_MAX));
          if (!expire) begin
            hold_d = hold_q + HOLD_W'(accept);
          end else begin
            hold_d = '0;
            if (other_req) begin
              grant_d = port_grant(!cur_p1);
              last_d  = !cur_p1;
            end else if (!own_req) begin
              grant_d = GNT_IDLE;
            end
          end
        end
      end
      default: grant_d = GNT_IDLE;
    endcase
  end

  // Output mux: the granted port drives the master; others see waitrequest.
  always_comb begin
    sel         = '0;
    bus.oWait_0 = 1'b1;
    bus.oWait_1 = 1'b1;
    case (grant_q)
      GNT_P0: begin
        sel         = req0;
        bus.oWait_0 = bus.iWrite_wait_request;
      end
      GNT_P1: begin
        sel         = req1;
        bus.oWait_1 = bus.iWrite_wait_request;
      end
      default: ;
    endcase
    bus.oAddr_OI    = sel.addr;
    bus.oData_to_OI = sel.data;
    bus.oWrreq_OI   = sel.wrreq;
    bus.oGrant      = grant_q;
    accept          = sel.wrreq & ~bus.iWrite_wait_request;
    stall           = sel.wrreq &  bus.iWrite_wait_request;
  end

  oi_sat_counter #(.W(CNT_W)) u_beats_0 (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (accept && (grant_q == GNT_P0)),
    .count (bus.oBeats_0)
  );

  oi_sat_counter #(.W(CNT_W)) u_beats_1 (
    .clk   (iClk),
    .rst_n (iReset_n),
    .inc   (accept && (grant_q == GNT_P1)),
    .count (bus.oBeats_1)
  );

endmodule
